// File: rtl/aurora_pkg.sv
// Shared Aurora definitions: 8b/10b character codes, ordered-set codes and
// the receive-side ordered-set decoder state encoding.
package aurora_pkg;

    localparam int INTERMEDIATE_DATA_SIZE = 8;
    localparam int SEQ_REPEAT             = 3;

    typedef logic [INTERMEDIATE_DATA_SIZE-1:0] char_t;

    localparam char_t K28_5 = 8'hBC;
    localparam char_t K28_2 = 8'h5C;
    localparam char_t K27_7 = 8'hFB;
    localparam char_t K29_7 = 8'hFD;
    localparam char_t K30_7 = 8'hFE;
    localparam char_t K28_4 = 8'h9C;
    localparam char_t K28_0 = 8'h1C;
    localparam char_t K28_3 = 8'h7C;
    localparam char_t K23_7 = 8'hF7;
    localparam char_t K28_6 = 8'hDC;
    localparam char_t D10_2 = 8'h4A;
    localparam char_t D12_1 = 8'h2C;
    localparam char_t D8_7  = 8'hE8;

    typedef enum logic [11:0] {
        OS_NONE = 12'h000,
        OS_P    = 12'h001,
        OS_SUF  = 12'h002,
        OS_R    = 12'h004,
        OS_A    = 12'h008,
        OS_SNF  = 12'h010,
        OS_K    = 12'h020,
        OS_SP   = 12'h040,
        OS_SPA  = 12'h080,
        OS_VER  = 12'h100,
        OS_SCP  = 12'h200,
        OS_ECP  = 12'h400,
        OS_CC   = 12'h800
    } ordered_sets_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_BC = 3'd1,
        ST_GOT_5C = 3'd2,
        ST_GOT_FD = 3'd3,
        ST_GOT_F7 = 3'd4,
        ST_SEQ    = 3'd5
    } dec_state_t;

    // Data character that, after K28.5, opens a repeated SP/SPA/VER set.
    function automatic logic is_seq_char(input char_t c);
        return (c == D10_2) || (c == D12_1) || (c == D8_7);
    endfunction

    function automatic ordered_sets_t seq_set(input char_t c);
        case (c)
            D10_2:   return OS_SP;
            D12_1:   return OS_SPA;
            D8_7:    return OS_VER;
            default: return OS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/os_event_queue.sv
// Small in-order FIFO of ordered-set events feeding a registered output.
// Up to two pushes per cycle (push0 ahead of push1), one pop per cycle.
module os_event_queue
    import aurora_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push0,
    input  ordered_sets_t i_data0,
    input  logic          i_push1,
    input  ordered_sets_t i_data1,
    output ordered_sets_t o_data,
    output logic          o_valid
);

    localparam int CW = $clog2(QUEUE_DEPTH + 3);

    ordered_sets_t r_mem [QUEUE_DEPTH];
    logic [CW-1:0] r_count;
    ordered_sets_t r_out;
    logic          r_valid;

    ordered_sets_t w_all [QUEUE_DEPTH+2];
    logic [CW-1:0] w_push1_pos;
    logic [CW-1:0] w_total;

    // Stored entries first, then this cycle's pushes; slot 0 is what leaves
    // next, so an empty queue lets a push go straight to the output.
    always_comb begin
        w_push1_pos = r_count + {{(CW-1){1'b0}}, i_push0};
        w_total     = w_push1_pos + {{(CW-1){1'b0}}, i_push1};
        for (int i = 0; i < QUEUE_DEPTH + 2; i++) begin
            w_all[i] = OS_NONE;
            if (i_push0 && (CW'(i) == r_count))
                w_all[i] = i_data0;
            if (i_push1 && (CW'(i) == w_push1_pos))
                w_all[i] = i_data1;
        end
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (CW'(i) < r_count)
                w_all[i] = r_mem[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_out   <= OS_NONE;
            r_valid <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                r_mem[i] <= OS_NONE;
        end else begin
            r_out   <= w_all[0];
            r_valid <= (w_total != '0);
            r_count <= (w_total != '0) ? w_total - 1'b1 : '0;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                r_mem[i] <= w_all[i+1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_total <= CW'(QUEUE_DEPTH + 1));

    assign o_data  = r_out;
    assign o_valid = r_valid;

endmodule

// File: rtl/ordered_sets_decoder.sv
// Receive-side ordered-set recogniser: turns the decoded character stream
// into one-cycle ordered-set pulses plus a seq_error pulse on bad sequences.
module ordered_sets_decoder
    import aurora_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INTERMEDIATE_DATA_SIZE-1:0] data_in,
    input  logic                              is_k,
    input  logic                              data_valid,
    output ordered_sets_t                     ordered_sets,
    output logic                              ordered_sets_valid,
    output logic                              seq_error,
    output dec_state_t                        o_dbg_state
);

    dec_state_t    r_state;
    char_t         r_exp;
    logic [1:0]    r_cnt;
    logic          r_err;

    dec_state_t    w_next_state;
    char_t         w_next_exp;
    logic [1:0]    w_next_cnt;
    logic          w_flush_k;
    logic          w_push_set;
    ordered_sets_t w_new_set;
    logic          w_err;
    logic          w_reidle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_exp   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_exp   <= w_next_exp;
            r_cnt   <= w_next_cnt;
            r_err   <= w_err;
        end
    end

    // A byte that does not continue the pending set is handed to the IDLE
    // decode in the same cycle (w_reidle), so nothing is ever dropped.
    always_comb begin
        w_next_state = r_state;
        w_next_exp   = r_exp;
        w_next_cnt   = r_cnt;
        w_flush_k    = 1'b0;
        w_push_set   = 1'b0;
        w_new_set    = OS_NONE;
        w_err        = 1'b0;
        w_reidle     = 1'b0;
        if (data_valid) begin
            case (r_state)
                ST_GOT_BC: begin
                    if (!is_k && is_seq_char(data_in)) begin
                        w_next_state = ST_SEQ;
                        w_next_exp   = data_in;
                        w_next_cnt   = 2'(SEQ_REPEAT - 1);
                    end else begin
                        w_flush_k = 1'b1;
                        w_reidle  = 1'b1;
                    end
                end
                ST_SEQ: begin
                    if (!is_k && (data_in == r_exp)) begin
                        if (r_cnt == 2'd1) begin
                            w_push_set   = 1'b1;
                            w_new_set    = seq_set(r_exp);
                            w_next_state = ST_IDLE;
                        end else begin
                            w_next_cnt = r_cnt - 2'd1;
                        end
                    end else begin
                        w_err    = 1'b1;
                        w_reidle = 1'b1;
                    end
                end
                ST_GOT_5C: begin
                    if (is_k && (data_in == K27_7)) begin
                        w_push_set   = 1'b1;
                        w_new_set    = OS_SCP;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_err    = 1'b1;
                        w_reidle = 1'b1;
                    end
                end
                ST_GOT_FD: begin
                    if (is_k && (data_in == K30_7)) begin
                        w_push_set   = 1'b1;
                        w_new_set    = OS_ECP;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_err    = 1'b1;
                        w_reidle = 1'b1;
                    end
                end
                ST_GOT_F7: begin
                    if (is_k && (data_in == K23_7)) begin
                        w_push_set   = 1'b1;
                        w_new_set    = OS_CC;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_err    = 1'b1;
                        w_reidle = 1'b1;
                    end
                end
                default: w_reidle = 1'b1;
            endcase

            if (w_reidle) begin
                w_next_state = ST_IDLE;
                if (is_k) begin
                    case (data_in)
                        K28_4: begin w_push_set = 1'b1; w_new_set = OS_P;   end
                        K28_0: begin w_push_set = 1'b1; w_new_set = OS_R;   end
                        K28_3: begin w_push_set = 1'b1; w_new_set = OS_A;   end
                        K28_6: begin w_push_set = 1'b1; w_new_set = OS_SNF; end
                        K28_5: w_next_state = ST_GOT_BC;
                        K28_2: w_next_state = ST_GOT_5C;
                        K29_7: w_next_state = ST_GOT_FD;
                        K23_7: w_next_state = ST_GOT_F7;
                        default: w_err = 1'b1;
                    endcase
                end
            end
        end
    end

    os_event_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push0 (w_flush_k),
        .i_data0 (OS_K),
        .i_push1 (w_push_set),
        .i_data1 (w_new_set),
        .o_data  (ordered_sets),
        .o_valid (ordered_sets_valid)
    );

    assign seq_error   = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ordered_sets_decoder.sv
// Bench for ordered_sets_decoder: directed vector table, reset corner cases,
// then random traffic checked against a pattern-matching reference model.
module tb_ordered_sets_decoder;
    import aurora_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          is_k = 1'b0;
    logic          data_valid = 1'b0;
    ordered_sets_t ordered_sets;
    logic          ordered_sets_valid;
    logic          seq_error;
    dec_state_t    o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ordered_sets_decoder #(.QUEUE_DEPTH(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .data_in            (data_in),
        .is_k               (is_k),
        .data_valid         (data_valid),
        .ordered_sets       (ordered_sets),
        .ordered_sets_valid (ordered_sets_valid),
        .seq_error          (seq_error),
        .o_dbg_state        (o_dbg_state)
    );

    typedef struct {
        logic          v;
        logic          k;
        logic [7:0]    d;
        ordered_sets_t es;
        logic          ee;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input ordered_sets_t es, input logic ee);
        check({tag, " set"},   32'(ordered_sets),       32'(es));
        check({tag, " valid"}, 32'(ordered_sets_valid), 32'(es != OS_NONE));
        check({tag, " err"},   32'(seq_error),          32'(ee));
    endtask

    // One character per cycle; outputs for that character are checked #1 after the edge.
    task automatic step(input logic v, input logic k, input logic [7:0] d,
                        input ordered_sets_t es, input logic ee, input string tag);
        @(negedge clk);
        data_valid = v;
        is_k       = k;
        data_in    = d;
        @(posedge clk);
        #1;
        check_outputs(tag, es, ee);
    endtask

    task automatic add(input logic v, input logic k, input logic [7:0] d,
                       input ordered_sets_t es, input logic ee);
        vec_t x;
        x.v = v; x.k = k; x.d = d; x.es = es; x.ee = ee;
        vecs.push_back(x);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst        = 1'b1;
        data_valid = 1'b0;
        #1;
        check_outputs(tag, OS_NONE, 1'b0);
        check({tag, " state"}, 32'(o_dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: characters since the last idle point are buffered and
    // matched against the ordered-set patterns; recognised sets go to a FIFO
    // that releases one set per cycle.
    typedef struct packed { logic k; logic [7:0] d; } chr_t;
    chr_t          pend[$];
    ordered_sets_t mq[$];
    bit            m_err;

    function automatic ordered_sets_t m_long_set(input logic [7:0] d);
        case (d)
            8'h4A:   return OS_SP;
            8'h2C:   return OS_SPA;
            default: return OS_VER;
        endcase
    endfunction

    function automatic void m_resolve();
        bit         again;
        int         j;
        logic [7:0] sd;
        logic [7:0] want;
        ordered_sets_t pset;
        again = 1'b1;
        while (again && pend.size() > 0) begin
            again = 1'b0;
            if (!pend[0].k) begin
                pend.delete();
            end else begin
                case (pend[0].d)
                    8'h9C: begin mq.push_back(OS_P);   pend.delete(); end
                    8'h1C: begin mq.push_back(OS_R);   pend.delete(); end
                    8'h7C: begin mq.push_back(OS_A);   pend.delete(); end
                    8'hDC: begin mq.push_back(OS_SNF); pend.delete(); end
                    8'hBC: begin
                        if (pend.size() >= 2) begin
                            if (!pend[1].k && (pend[1].d == 8'h4A || pend[1].d == 8'h2C || pend[1].d == 8'hE8)) begin
                                sd = pend[1].d;
                                j  = 2;
                                while (j < pend.size() && pend[j] == {1'b0, sd}) j++;
                                if (j < pend.size()) begin
                                    m_err = 1'b1;
                                    repeat (j) void'(pend.pop_front());
                                    again = 1'b1;
                                end else if (pend.size() == 1 + 3) begin
                                    mq.push_back(m_long_set(sd));
                                    pend.delete();
                                end
                            end else begin
                                mq.push_back(OS_K);
                                void'(pend.pop_front());
                                again = 1'b1;
                            end
                        end
                    end
                    8'h5C, 8'hFD, 8'hF7: begin
                        if (pend.size() >= 2) begin
                            case (pend[0].d)
                                8'h5C:   begin want = 8'hFB; pset = OS_SCP; end
                                8'hFD:   begin want = 8'hFE; pset = OS_ECP; end
                                default: begin want = 8'hF7; pset = OS_CC;  end
                            endcase
                            if (pend[1].k && pend[1].d == want) begin
                                mq.push_back(pset);
                                pend.delete();
                            end else begin
                                m_err = 1'b1;
                                void'(pend.pop_front());
                                again = 1'b1;
                            end
                        end
                    end
                    default: begin m_err = 1'b1; pend.delete(); end
                endcase
            end
        end
    endfunction

    task automatic model_step(input logic v, input logic k, input logic [7:0] d,
                              output ordered_sets_t es, output logic ee);
        m_err = 1'b0;
        if (v) begin
            pend.push_back({k, d});
            m_resolve();
        end
        ee = m_err;
        es = OS_NONE;
        if (mq.size() > 0) es = mq.pop_front();
    endtask

    logic [7:0] pool [15] = '{8'hBC, 8'h5C, 8'hFB, 8'hFD, 8'hFE, 8'h9C, 8'h1C, 8'h7C,
                              8'hF7, 8'hDC, 8'h3C, 8'h4A, 8'h2C, 8'hE8, 8'h00};

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por", OS_NONE, 1'b0);
        check("por state", 32'(o_dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // SP / SPA / VER
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'h4A,OS_NONE,0); add(1,0,8'h4A,OS_NONE,0); add(1,0,8'h4A,OS_SP,0);
        add(0,0,8'h00,OS_NONE,0);
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'h2C,OS_NONE,0); add(1,0,8'h2C,OS_NONE,0); add(1,0,8'h2C,OS_SPA,0);
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'hE8,OS_NONE,0); add(1,0,8'hE8,OS_NONE,0); add(1,0,8'hE8,OS_VER,0);
        // Lookahead flush
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'h00,OS_K,0);
        add(1,1,8'hBC,OS_NONE,0); add(1,1,8'hBC,OS_K,0); add(1,1,8'hBC,OS_K,0); add(1,0,8'h00,OS_K,0);
        add(1,1,8'hBC,OS_NONE,0); add(1,1,8'h1C,OS_K,0); add(1,1,8'hBC,OS_R,0); add(1,1,8'h7C,OS_K,0);
        add(0,0,8'h00,OS_A,0);
        // Two-character sets
        add(1,1,8'h5C,OS_NONE,0); add(1,1,8'hFB,OS_SCP,0);
        add(1,1,8'hFD,OS_NONE,0); add(1,1,8'hFE,OS_ECP,0);
        add(1,1,8'hF7,OS_NONE,0); add(1,1,8'hF7,OS_CC,0);
        add(1,1,8'h5C,OS_NONE,0); add(1,1,8'h1C,OS_R,1);
        // Errors
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'h4A,OS_NONE,0); add(1,0,8'h2C,OS_NONE,1);
        add(1,0,8'h2C,OS_NONE,0); add(1,0,8'h2C,OS_NONE,0);
        add(1,1,8'h3C,OS_NONE,1);
        add(1,1,8'hBC,OS_NONE,0); add(1,0,8'h4A,OS_NONE,0); add(1,1,8'h9C,OS_P,1);
        // Single-character sets
        add(1,1,8'h9C,OS_P,0); add(1,1,8'hDC,OS_SNF,0); add(1,1,8'h7C,OS_A,0);
        // K flush followed by a two-character set
        add(1,1,8'hBC,OS_NONE,0); add(1,1,8'h5C,OS_K,0); add(1,1,8'hFB,OS_SCP,0);
        // data_valid gaps
        add(1,1,8'hBC,OS_NONE,0); add(0,0,8'h4A,OS_NONE,0); add(1,0,8'h4A,OS_NONE,0); add(0,1,8'hBC,OS_NONE,0);
        add(1,0,8'h4A,OS_NONE,0); add(0,0,8'h00,OS_NONE,0); add(0,0,8'h00,OS_NONE,0); add(1,0,8'h4A,OS_SP,0);
        add(1,1,8'hBC,OS_NONE,0); add(1,1,8'h1C,OS_K,0); add(0,0,8'h00,OS_R,0);
        // Lone trailing K28.5 waits for the next valid byte
        add(1,1,8'hBC,OS_NONE,0); add(0,0,8'h00,OS_NONE,0); add(0,0,8'h00,OS_NONE,0);
        add(1,1,8'h9C,OS_K,0); add(0,0,8'h00,OS_P,0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].v, vecs[i].k, vecs[i].d, vecs[i].es, vecs[i].ee, $sformatf("vec%0d", i));

        // Reset while an output is showing, then mid-sequence, then with a queued entry
        step(1,1,8'h9C,OS_P,0,"rst_a pre");
        async_reset("rst_a");
        step(1,1,8'hBC,OS_NONE,0,"rst_b bc");
        step(1,0,8'h4A,OS_NONE,0,"rst_b 4a");
        async_reset("rst_b");
        for (int i = 0; i < 3; i++)
            step(1,0,8'h4A,OS_NONE,0,$sformatf("rst_b post%0d", i));
        step(0,0,8'h00,OS_NONE,0,"rst_b idle");
        step(1,1,8'hBC,OS_NONE,0,"rst_c bc");
        step(1,1,8'h1C,OS_K,0,"rst_c 1c");
        async_reset("rst_c");
        step(0,0,8'h00,OS_NONE,0,"rst_c drained");

        // Random traffic against the reference model
        pend.delete();
        mq.delete();
        begin
            logic [7:0] pd;
            logic       pk;
            logic       pv;
            int         idx;
            int         rep;
            ordered_sets_t es;
            logic       ee;
            pd = 8'h00;
            pk = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                pv = ($urandom_range(0, 9) != 0);
                rep = (!pk && (pd == 8'h4A || pd == 8'h2C || pd == 8'hE8)) ? 6 : 2;
                if (pk && pd == 8'hBC && $urandom_range(0, 1) == 1) begin
                    idx = 11 + $urandom_range(0, 2);
                    pd  = pool[idx];
                    pk  = 1'b0;
                end else if ($urandom_range(0, 9) < rep) begin
                    pd = pd;
                end else begin
                    idx = $urandom_range(0, 14);
                    pd  = pool[idx];
                    pk  = (idx < 11);
                    if ($urandom_range(0, 19) == 0) pk = ~pk;
                end
                model_step(pv, pk, pd, es, ee);
                step(pv, pk, pd, es, ee, $sformatf("rnd%0d", c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
